spi_eep: RTL and testbench



---
 rtl/spi_eep.sv | 91 +++++++++
 tb/tb_spi_eep.sv | 116 +++++++++++
 2 files changed

// File: rtl/spi_eep.sv
// SPI-slave model of the 64x8 calibration EEPROM. Bus inputs are oversampled on clk,
// and 16-bit frames {cmd[1:0], addr[5:0], data[7:0]} execute when SS_n rises.
module spi_eep #(
  parameter logic [7:0] INIT_VAL = 8'h00
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO
);

  localparam logic [1:0] CMD_RD = 2'b00;
  localparam logic [1:0] CMD_WR = 2'b01;
  localparam logic [4:0] CNT_MAX = 5'd17;

  // [0],[1] synchronizer, [2] history for edge detection
  logic [2:0]  ss_q, sclk_q, mosi_q;
  logic [15:0] rx, rx_nxt, tx;
  logic [4:0]  cnt, cnt_nxt;
  logic [7:0]  rd_data;
  logic [7:0]  mem [64];

  logic in_frame, ss_fall, ss_rise, sclk_rise, sclk_fall, exec;
  logic [1:0] cmd;
  logic [5:0] addr;
  logic [7:0] data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q   <= 3'b111;
      sclk_q <= 3'b000;
      mosi_q <= 3'b000;
    end else begin
      ss_q   <= {ss_q[1:0], SS_n};
      sclk_q <= {sclk_q[1:0], SCLK};
      mosi_q <= {mosi_q[1:0], MOSI};
    end
  end

  assign in_frame  = ~ss_q[2];
  assign ss_fall   = ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign sclk_rise = in_frame & ~sclk_q[2] & sclk_q[1];
  assign sclk_fall = in_frame & sclk_q[2] & ~sclk_q[1];

  // Next-state of the receive side, so a final SCLK rise coinciding with SS_n rise
  // is folded into the frame before it is evaluated.
  always_comb begin
    rx_nxt  = rx;
    cnt_nxt = cnt;
    if (sclk_rise) begin
      rx_nxt = {rx[14:0], mosi_q[2]};
      if (cnt != CNT_MAX) cnt_nxt = cnt + 5'd1;
    end
  end

  assign cmd  = rx_nxt[15:14];
  assign addr = rx_nxt[13:8];
  assign data = rx_nxt[7:0];
  assign exec = ss_rise && (cnt_nxt == 5'd16);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx  <= '0;
      tx  <= '0;
      cnt <= '0;
    end else if (ss_fall) begin
      cnt <= '0;
      tx  <= {8'h00, rd_data};
    end else begin
      rx  <= rx_nxt;
      cnt <= cnt_nxt;
      if (sclk_fall) tx <= {tx[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= INIT_VAL;
      rd_data <= INIT_VAL;
    end else if (exec) begin
      if (cmd == CMD_WR) mem[addr] <= data;
      if (cmd == CMD_RD) rd_data <= mem[addr];
    end
  end

  assign MISO = ss_q[2] ? 1'bz : tx[15];

endmodule

// File: tb/tb_spi_eep.sv
// Directed bench for spi_eep: bit-banged SPI master, hand-computed MISO words.
module tb_spi_eep;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic SS_n = 1'b1;
  logic SCLK = 1'b0;
  logic MOSI = 1'b0;
  logic MISO;

  int total = 0;
  int bad = 0;
  logic [15:0] rd;

  spi_eep #(.INIT_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sends nbits of word MSB first; captures the first 16 MISO bits before each SCLK rise.
  task automatic spi_xfer(input logic [31:0] word, input int nbits, input bit hold,
                          output logic [15:0] miso_w);
    miso_w = '0;
    @(negedge clk) SS_n = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      MOSI = word[i];
      repeat (5) @(negedge clk);
      if (nbits - 1 - i < 16) miso_w = {miso_w[14:0], MISO};
      SCLK = 1'b1;
      repeat (5) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (5) @(negedge clk);
    if (!hold) begin
      SS_n = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic frame(input logic [15:0] word, input string tag, input logic [15:0] exp);
    logic [15:0] m;
    spi_xfer({16'h0, word}, 16, 1'b0, m);
    chk(tag, m, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_miso_z", {15'b0, MISO === 1'bz}, 16'h0001);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_miso_z", {15'b0, MISO === 1'bz}, 16'h0001);

    // reset then read
    frame(16'h0500, "rst_rd_f1", 16'h0000);
    frame(16'h0000, "rst_rd_f2", 16'h0000);

    // write / readback
    frame(16'h4AC3, "wr_0a", 16'h0000);
    frame(16'h0A00, "rd_0a_req", 16'h0000);
    frame(16'h8000, "rd_0a_data", 16'h00C3);

    // address extremes
    frame(16'h4011, "wr_00", 16'h00C3);
    frame(16'h7FEE, "wr_3f", 16'h00C3);
    frame(16'h0000, "rd_00_req", 16'h00C3);
    frame(16'h3F00, "rd_00_data", 16'h0011);
    frame(16'h8000, "rd_3f_data", 16'h00EE);

    // short (12-bit) and long (18-bit) write frames are discarded
    spi_xfer(32'h0000_0437, 12, 1'b0, rd);
    frame(16'h0300, "rd_03_req", 16'h00EE);
    frame(16'h8000, "short_discard", 16'h0000);
    spi_xfer({14'h0, 16'h4377, 2'b01}, 18, 1'b0, rd);
    chk("long_miso", rd, 16'h0000);
    frame(16'h0300, "rd_03_req2", 16'h0000);
    frame(16'h8000, "long_discard", 16'h0000);

    // no-op commands leave rd_data and memory alone
    frame(16'h425A, "wr_02", 16'h0000);
    frame(16'h0200, "rd_02_req", 16'h0000);
    frame(16'hC2FF, "noop_c", 16'h005A);
    chk("noop_miso_z", {15'b0, MISO === 1'bz}, 16'h0001);
    frame(16'h8000, "noop_keep", 16'h005A);
    frame(16'h0200, "rd_02_req2", 16'h005A);
    frame(16'h8000, "rd_02_data", 16'h005A);

    // reset in the middle of a write after 10 bits
    spi_xfer({16'h0, 16'h4977}, 10, 1'b1, rd);
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    SS_n = 1'b1;
    chk("midrst_miso_z", {15'b0, MISO === 1'bz}, 16'h0001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    frame(16'h0900, "midrst_rd_req", 16'h0000);
    frame(16'h0A00, "midrst_rd_09", 16'h0000);
    frame(16'h4977, "midrst_rd_0a", 16'h0000);
    frame(16'h0900, "post_rd_req", 16'h0000);
    frame(16'h8000, "post_rd_09", 16'h0077);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
